// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter (reverse double dabble).
// Each SHIFT cycle shifts the {bcd, bin} register right by one. It then applies a
// subtract-3 correction to every BCD nibble that reads 8 or more. After BIN_W
// iterations the low BIN_W bits hold the binary value.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    conversion request, sampled only in IDLE
//   bcd_in   DIGITS digit codes, index DIGITS-1 most significant; 0-9 or 15 (leading blank)
//   busy     high while converting (SHIFT state)
//   done     one-cycle pulse, bin_out/err valid
//   err      input rejected; held until the next accepted start
//   bin_out  converted value, held until the next done
module bcd_to_bin #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       bcd_in [0:DIGITS-1],
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] bin_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BIN_W-1:0]   bin_q, bin_d;

    logic               in_valid;
    logic               seen_digit;
    logic [BCD_W-1:0]   bcd_load;
    logic [SR_W-1:0]    sr_iter;
    logic               last_iter;

    // Validation and load image, both from the unlatched input.
    // Blanks (15) are legal only above every real digit; they load as 0.
    always_comb begin
        in_valid   = 1'b1;
        seen_digit = 1'b0;
        bcd_load   = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (bcd_in[i] == 4'd15) begin
                if (seen_digit) begin
                    in_valid = 1'b0;
                end
            end else begin
                seen_digit = 1'b1;
                bcd_load[4*i +: 4] = bcd_in[i];
                if (bcd_in[i] > 4'd9) begin
                    in_valid = 1'b0;
                end
            end
        end
    end

    // One reverse double dabble iteration: shift right, then correct each BCD nibble.
    always_comb begin
        sr_iter = sr_q >> 1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sr_iter[BIN_W + 4*i +: 4] >= 4'd8) begin
                sr_iter[BIN_W + 4*i +: 4] = sr_iter[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sr_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && in_valid) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (last_iter) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        done_d = 1'b0;
        err_d  = err_q;
        bin_d  = bin_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (in_valid) begin
                        sr_d  = {bcd_load, {BIN_W{1'b0}}};
                        cnt_d = '0;
                        err_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        bin_d  = '0;
                    end
                end
            end
            StShift: begin
                sr_d  = sr_iter;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    bin_d  = sr_iter[BIN_W-1:0];
                    done_d = 1'b1;
                    err_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy    = (state_q == StShift);
    assign done    = done_q;
    assign err     = err_q;
    assign bin_out = bin_q;

endmodule
